// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a framed program image, writes it word by word onto the
// memory bus and releases the CPU core once the image checksum matches.
module uart_boot_loader #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter logic [15:0] MAX_WORDS    = 16'd4096
) (
   input  logic        CLK,
   input  logic        HRESET,
   input  logic        PIN_RX,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   output logic        HTRANS,
   output logic        CPU_HRESET,
   output logic        boot_done,
   output logic        boot_err
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
   typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

   logic          rxMeta_q, rxSync_q, rxPrev_q;
   rxState_t      rxState_q, rxState_d;
   logic [CW-1:0] rxCnt_q, rxCnt_d;
   logic [2:0]    rxBit_q, rxBit_d;
   logic [7:0]    rxShift_q, rxShift_d;
   logic          rxValid_q, rxValid_d;
   logic          rxFerr_q, rxFerr_d;

   state_t        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   wordIdx_q, wordIdx_d;
   logic [1:0]    byteIdx_q, byteIdx_d;
   logic [31:0]   wordBuf_q, wordBuf_d;
   logic [7:0]    chk_q, chk_d;
   logic [31:0]   haddr_q, haddr_d;
   logic [31:0]   hwdata_q, hwdata_d;
   logic          hwrite_q, hwrite_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [15:0]   lenFull;

   always_ff @(posedge CLK or negedge HRESET) begin
      if (!HRESET) begin
         rxMeta_q  <= 1'b1;
         rxSync_q  <= 1'b1;
         rxPrev_q  <= 1'b1;
         rxState_q <= RX_IDLE;
         rxCnt_q   <= '0;
         rxBit_q   <= '0;
         rxShift_q <= '0;
         rxValid_q <= 1'b0;
         rxFerr_q  <= 1'b0;
      end else begin
         rxMeta_q  <= PIN_RX;
         rxSync_q  <= rxMeta_q;
         rxPrev_q  <= rxSync_q;
         rxState_q <= rxState_d;
         rxCnt_q   <= rxCnt_d;
         rxBit_q   <= rxBit_d;
         rxShift_q <= rxShift_d;
         rxValid_q <= rxValid_d;
         rxFerr_q  <= rxFerr_d;
      end
   end

   // Start bit is re-checked at half a bit so short low glitches never start a byte.
   always_comb begin
      rxState_d = rxState_q;
      rxCnt_d   = rxCnt_q + CW'(1);
      rxBit_d   = rxBit_q;
      rxShift_d = rxShift_q;
      rxValid_d = 1'b0;
      rxFerr_d  = 1'b0;
      case (rxState_q)
         RX_IDLE: begin
            rxCnt_d = '0;
            if (rxPrev_q && !rxSync_q) rxState_d = RX_START;
         end
         RX_START: begin
            if (rxCnt_q == HALF_CNT) begin
               rxCnt_d   = '0;
               rxBit_d   = '0;
               rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rxCnt_q == FULL_CNT) begin
               rxCnt_d   = '0;
               rxShift_d = {rxSync_q, rxShift_q[7:1]};
               rxBit_d   = rxBit_q + 3'd1;
               if (rxBit_q == 3'd7) rxState_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rxCnt_q == FULL_CNT) begin
               rxValid_d = rxSync_q;
               rxFerr_d  = !rxSync_q;
               rxState_d = RX_IDLE;
            end
         end
         default: rxState_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge HRESET) begin
      if (!HRESET) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         wordIdx_q <= '0;
         byteIdx_q <= '0;
         wordBuf_q <= '0;
         chk_q     <= '0;
         haddr_q   <= '0;
         hwdata_q  <= '0;
         hwrite_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         wordIdx_q <= wordIdx_d;
         byteIdx_q <= byteIdx_d;
         wordBuf_q <= wordBuf_d;
         chk_q     <= chk_d;
         haddr_q   <= haddr_d;
         hwdata_q  <= hwdata_d;
         hwrite_q  <= hwrite_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign lenFull = {rxShift_q, len_q[7:0]};

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wordIdx_d = wordIdx_q;
      byteIdx_d = byteIdx_q;
      wordBuf_d = wordBuf_q;
      chk_d     = chk_q;
      haddr_d   = haddr_q;
      hwdata_d  = hwdata_q;
      hwrite_d  = 1'b0;
      done_d    = done_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (rxValid_q && rxShift_q == 8'hA5) begin
               state_d   = S_LEN_LO;
               wordIdx_d = '0;
               byteIdx_d = '0;
               chk_d     = '0;
               err_d     = 1'b0;
            end
         end
         S_LEN_LO: begin
            if (rxFerr_q) state_d = S_ERR;
            else if (rxValid_q) begin
               len_d[7:0] = rxShift_q;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (rxFerr_q) state_d = S_ERR;
            else if (rxValid_q) begin
               len_d = lenFull;
               if (lenFull == 16'd0)           state_d = S_CHK;
               else if (lenFull > MAX_WORDS)   state_d = S_ERR;
               else                            state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rxFerr_q) state_d = S_ERR;
            else if (rxValid_q) begin
               chk_d     = chk_q + rxShift_q;
               byteIdx_d = byteIdx_q + 2'd1;
               if (byteIdx_q == 2'd3) begin
                  hwrite_d  = 1'b1;
                  haddr_d   = BASE_ADDR + {14'd0, wordIdx_q, 2'b00};
                  hwdata_d  = {rxShift_q, wordBuf_q[23:0]};
                  wordIdx_d = wordIdx_q + 16'd1;
                  if (wordIdx_q == len_q - 16'd1) state_d = S_CHK;
               end else begin
                  wordBuf_d[8*byteIdx_q +: 8] = rxShift_q;
               end
            end
         end
         S_CHK: begin
            if (rxFerr_q) state_d = S_ERR;
            else if (rxValid_q) begin
               if (rxShift_q == chk_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      // Every path into ERR flags the failed attempt.
      if (state_d == S_ERR && state_q != S_ERR) err_d = 1'b1;
   end

   assign HADDR      = haddr_q;
   assign HWDATA     = hwdata_q;
   assign HWRITE     = hwrite_q;
   assign HTRANS     = hwrite_q;
   assign CPU_HRESET = done_q;
   assign boot_done  = done_q;
   assign boot_err   = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: directed and random frames checked by a frame-level
// reference model and a write scoreboard.
module tb_uart_boot_loader;

   localparam int CPB = 8;
   localparam int MAXW = 4096;

   logic        CLK = 1'b0;
   logic        HRESET = 1'b0;
   logic        PIN_RX = 1'b1;
   logic [31:0] HADDR, HWDATA;
   logic        HWRITE, HTRANS, CPU_HRESET, boot_done, boot_err;

   typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;

   wr_t          expQ[$];
   byte unsigned txQ[$];
   int           badIdx = -1;
   bit           mDone = 0, mErr = 0;
   int           testCount = 0, failCount = 0;

   uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(16'(MAXW))) dut (
      .CLK(CLK), .HRESET(HRESET), .PIN_RX(PIN_RX),
      .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HTRANS(HTRANS),
      .CPU_HRESET(CPU_HRESET), .boot_done(boot_done), .boot_err(boot_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every bus write cycle must match the oldest expected write.
   always @(negedge CLK) begin
      if (HRESET && (HWRITE || HTRANS)) begin
         wr_t w;
         check("write HWRITE", {31'd0, HWRITE}, 32'd1);
         check("write HTRANS", {31'd0, HTRANS}, 32'd1);
         if (expQ.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL unexpected write: addr %h data %h, none expected", HADDR, HWDATA);
         end else begin
            w = expQ.pop_front();
            check("write HADDR", HADDR, w.addr);
            check("write HWDATA", HWDATA, w.data);
         end
      end
   end

   task automatic sendByte(input byte unsigned b, input bit badStop);
      PIN_RX = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         PIN_RX = b[i];
         repeat (CPB) @(negedge CLK);
      end
      PIN_RX = !badStop;
      repeat (CPB) @(negedge CLK);
      PIN_RX = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   // Frame-level reference model, then send the frame (stopping at a corrupted byte).
   task automatic applyStimulus();
      int len, lastIdx;
      bit ok;
      byte unsigned sum;
      wr_t w;
      lastIdx = (badIdx >= 0) ? badIdx : txQ.size() - 1;
      if (!mDone) begin
         if (badIdx == 1 || badIdx == 2) mErr = 1;
         else begin
            len = int'(txQ[1]) + 256 * int'(txQ[2]);
            if (len > MAXW) mErr = 1;
            else begin
               sum = 0;
               ok  = 1;
               for (int wd = 0; wd < len && ok; wd++) begin
                  if (badIdx >= 3 + 4*wd && badIdx < 7 + 4*wd) ok = 0;
                  else begin
                     w.addr = 32'(4 * wd);
                     w.data = {txQ[6+4*wd], txQ[5+4*wd], txQ[4+4*wd], txQ[3+4*wd]};
                     expQ.push_back(w);
                     for (int k = 0; k < 4; k++) sum = sum + txQ[3+4*wd+k];
                  end
               end
               if (!ok || badIdx == 3 + 4*len || sum != txQ[3+4*len]) mErr = 1;
               else begin
                  mDone = 1;
                  mErr  = 0;
               end
            end
         end
      end
      for (int i = 0; i <= lastIdx; i++) sendByte(txQ[i], i == badIdx);
   endtask

   task automatic checkOutput(input string tag);
      repeat (4) @(negedge CLK);
      check({tag, " boot_done"}, {31'd0, boot_done}, {31'd0, mDone});
      check({tag, " boot_err"}, {31'd0, boot_err}, {31'd0, mErr});
      check({tag, " CPU_HRESET"}, {31'd0, CPU_HRESET}, {31'd0, mDone});
      check({tag, " pending writes"}, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   task automatic doReset();
      @(negedge CLK);
      #2 HRESET = 1'b0;
      #1;
      check("rst HADDR", HADDR, 32'd0);
      check("rst HWDATA", HWDATA, 32'd0);
      check("rst HWRITE", {31'd0, HWRITE}, 32'd0);
      check("rst HTRANS", {31'd0, HTRANS}, 32'd0);
      check("rst CPU_HRESET", {31'd0, CPU_HRESET}, 32'd0);
      check("rst boot_done", {31'd0, boot_done}, 32'd0);
      check("rst boot_err", {31'd0, boot_err}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         PIN_RX = ~PIN_RX;
         @(negedge CLK);
      end
      PIN_RX = 1'b1;
      check("rst held CPU_HRESET", {31'd0, CPU_HRESET}, 32'd0);
      HRESET = 1'b1;
      mDone = 0;
      mErr  = 0;
      expQ.delete();
      repeat (4) @(negedge CLK);
      check("post-rst CPU_HRESET", {31'd0, CPU_HRESET}, 32'd0);
   endtask

   task automatic makeRandom(input int nWords, input int mode);
      byte unsigned s, d;
      s = 0;
      txQ.delete();
      txQ.push_back(8'hA5);
      txQ.push_back(8'(nWords));
      txQ.push_back(8'h00);
      for (int i = 0; i < 4 * nWords; i++) begin
         d = 8'($urandom);
         txQ.push_back(d);
         s = s + d;
      end
      txQ.push_back(mode == 1 ? (s ^ 8'(1 << $urandom_range(0, 7))) : s);
      badIdx = (mode == 2) ? int'($urandom_range(1, txQ.size() - 1)) : -1;
   endtask

   initial begin
      wr_t w;
      doReset();

      txQ = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
      badIdx = -1;
      applyStimulus();
      checkOutput("good frame");

      doReset();
      txQ[11] = 8'h83;
      applyStimulus();
      checkOutput("bad chk");
      txQ[11] = 8'h82;
      applyStimulus();
      checkOutput("resend");

      doReset();
      txQ = '{8'hA5, 8'h01, 8'h10};
      applyStimulus();
      checkOutput("overlength");
      txQ = '{8'hA5, 8'h00, 8'h00, 8'h00};
      applyStimulus();
      checkOutput("len0");

      doReset();
      txQ = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
      badIdx = 5;
      applyStimulus();
      checkOutput("framing");
      PIN_RX = 1'b0;
      repeat (CPB / 4) @(negedge CLK);
      PIN_RX = 1'b1;
      repeat (CPB) @(negedge CLK);
      badIdx = -1;
      applyStimulus();
      checkOutput("after glitch");

      doReset();
      txQ = '{8'hA5, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
      w.addr = 32'h0;
      w.data = 32'hEFBEADDE;
      expQ.push_back(w);
      for (int i = 0; i < 9; i++) sendByte(txQ[i], 1'b0);
      check("abort pending writes", 32'(expQ.size()), 32'd0);
      doReset();
      txQ = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
      applyStimulus();
      checkOutput("after abort");

      for (int it = 0; it < 12; it++) begin
         if (mDone) doReset();
         makeRandom(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
         applyStimulus();
         checkOutput("random");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
